// File: rtl/stopwatch_control.sv
// stopwatch_control: push-button conditioning and mode FSM in front of the stopwatch counter chain.
// Define STOPWATCH_LAP_EN to build the lap button path and the LAP state.

module stopwatch_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Count only while the synchronised input disagrees with the accepted level;
            // acceptance happens on the edge after the count reaches its limit.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

module stopwatch_control #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic       tick_out,
    output logic       clear_out,
    output logic       freeze,
    output logic       running,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    state_t st;
    logic   ss_press;
    logic   clr_press;
    logic   lap_press;

    stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start_stop (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_start_stop),
        .press (ss_press)
    );

    stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_clear),
        .press (clr_press)
    );

`ifdef STOPWATCH_LAP_EN
    stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_lap),
        .press (lap_press)
    );
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
    assign lap_press  = 1'b0;
`endif

    // running/freeze are written alongside every state change so they track the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            tick_out  <= 1'b0;
            clear_out <= 1'b0;
            freeze    <= 1'b0;
            running   <= 1'b0;
        end else begin
            tick_out  <= tick_in & ((st == RUN) || (st == LAP));
            clear_out <= 1'b0;
            case (st)
                IDLE: begin
                    if (ss_press) begin
                        st      <= RUN;
                        running <= 1'b1;
                        freeze  <= 1'b0;
                    end else if (clr_press) begin
                        clear_out <= 1'b1;
                    end
                end
                RUN: begin
                    if (ss_press) begin
                        st      <= PAUSE;
                        running <= 1'b0;
                        freeze  <= 1'b0;
                    end else if (lap_press) begin
                        st      <= LAP;
                        running <= 1'b1;
                        freeze  <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (ss_press) begin
                        st      <= RUN;
                        running <= 1'b1;
                        freeze  <= 1'b0;
                    end else if (clr_press) begin
                        st        <= IDLE;
                        running   <= 1'b0;
                        freeze    <= 1'b0;
                        clear_out <= 1'b1;
                    end
                end
                LAP: begin
                    if (ss_press) begin
                        st      <= PAUSE;
                        running <= 1'b0;
                        freeze  <= 1'b0;
                    end else if (lap_press) begin
                        st      <= RUN;
                        running <= 1'b1;
                        freeze  <= 1'b0;
                    end
                end
                default: begin
                    st      <= IDLE;
                    running <= 1'b0;
                    freeze  <= 1'b0;
                end
            endcase
        end
    end

    assign state = st;

endmodule
